// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-level round-robin arbiter in front of a UART TX FIFO write port.
// Optional per-message source header byte: define UART_TX_ARB_HDR_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
`ifdef UART_TX_ARB_HDR_EN
  parameter logic [7:0] HDR_TAG = 8'hA0,
`endif
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        txdata,
  output logic              txdata_valid,
  input  logic              txfifo_full,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              abort,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester byte moves on any cycle with req_valid[g] && req_ready[g];
  // a FIFO write happens on any cycle with txdata_valid && !txfifo_full.

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef UART_TX_ARB_HDR_EN
    S_HDR  = 2'd1,
`endif
    S_DATA = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_last;
  logic [GW-1:0] r_grant_id;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_busy;
  logic          r_abort;

  logic [GW-1:0] w_cand [NREQ];
  logic [7:0]    w_bytes [NREQ];
  logic [GW-1:0] w_pick;
  logic          w_pick_vld;
  logic          w_valid_g;
  logic          w_last_g;
  logic          w_xfer;
  logic          w_done;
  logic          w_expire;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_bytes[k] = req_data[k*8 +: 8];
      w_cand[k]  = GW'((int'(r_last) + k + 1) % NREQ);
    end
  end

  // Walk candidates from farthest to nearest so the nearest valid one after r_last wins.
  always_comb begin
    w_pick     = r_last;
    w_pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[w_cand[k]]) begin
        w_pick     = w_cand[k];
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_valid_g = req_valid[r_grant_id];
  assign w_last_g  = req_last[r_grant_id];

  always_comb begin
    w_state_nxt  = r_state;
    txdata       = 8'h00;
    txdata_valid = 1'b0;
    req_ready    = '0;
    w_xfer       = 1'b0;
    w_done       = 1'b0;
    w_expire     = 1'b0;
    w_cnt_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
`ifdef UART_TX_ARB_HDR_EN
          w_state_nxt = S_HDR;
`else
          w_state_nxt = S_DATA;
`endif
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      S_HDR: begin
        txdata       = HDR_TAG | 8'(r_grant_id);
        txdata_valid = 1'b1;
        if (!txfifo_full) w_state_nxt = S_DATA;
      end
`endif
      S_DATA: begin
        txdata                = w_bytes[r_grant_id];
        txdata_valid          = w_valid_g;
        req_ready[r_grant_id] = !txfifo_full;
        w_xfer                = w_valid_g && !txfifo_full;
        w_done                = w_xfer && w_last_g;
        // A valid byte held off by a full FIFO is not a stall; only missing data counts.
        if (w_valid_g)                 w_cnt_nxt = '0;
        else if (r_cnt != CW'(TIMEOUT)) w_cnt_nxt = r_cnt + 1'b1;
        else                           w_cnt_nxt = r_cnt;
        w_expire = (TIMEOUT != 0) && !w_done && (w_cnt_nxt == CW'(TIMEOUT));
        if (w_done || w_expire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= GW'(NREQ - 1);
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_abort <= w_expire;
      // The counter only lives in DATA, so entering DATA always starts it from zero.
      r_cnt   <= (w_state_nxt == S_DATA && r_state == S_DATA) ? w_cnt_nxt : '0;
      if (r_state == S_IDLE && w_pick_vld) r_grant_id <= w_pick;
      if (w_done || w_expire)              r_last     <= r_grant_id;
    end
  end

  assign busy      = r_busy;
  assign abort     = r_abort;
  assign grant_id  = r_grant_id;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized messages, message-level round-robin reference model,
// scoreboard of FIFO writes and grants. Works with or without UART_TX_ARB_HDR_EN.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam int GW      = $clog2(NREQ);
  localparam logic [7:0] HDR_TAG = 8'hA0;
`ifdef UART_TX_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        txdata;
  logic              txdata_valid;
  logic              txfifo_full;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              abort;
  logic [1:0]        dbg_state;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .txdata(txdata),
    .txdata_valid(txdata_valid), .txfifo_full(txfifo_full), .busy(busy),
    .grant_id(grant_id), .abort(abort), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
    n_checks++;
    if (act === expd) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expd);
  endtask

  task automatic fail_now(input string name, input string detail);
    n_checks++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // driver state: per-requester byte queues with idle gap before each byte
  logic [7:0] drv_b [NREQ][$];
  logic       drv_l [NREQ][$];
  int         drv_g [NREQ][$];
  int         full_hold = 0;
  bit         rand_full = 1'b0;
  logic [NREQ-1:0] hs;
  int         rise_cyc [NREQ];

  // reference model: pending messages per requester, arbitration pointer
  logic [7:0]    m_b [NREQ][$];
  logic          m_l [NREQ][$];
  int            m_last = NREQ - 1;
  logic [7:0]    exp_q [$];
  logic [GW-1:0] exp_g [$];
  int            exp_aborts = 0;

  // monitor state
  logic prev_busy = 1'b0;
  int wr_count = 0, abort_seen = 0, abort_gap = -1;
  int first_wr_cyc = -1, last_wr_cyc = 0, grant_cyc = 0;

  function automatic bit drv_empty();
    for (int r = 0; r < NREQ; r++) if (drv_b[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Round robin at message granularity: next requester after the previous grantee that
  // has a pending message gets its whole message (optionally header first).
  task automatic model_run();
    int g;
    bit found;
    logic l;
    do begin
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= NREQ && !found; k++) begin
        g = (m_last + k) % NREQ;
        if (m_b[g].size() > 0) found = 1'b1;
      end
      if (found) begin
        exp_g.push_back(GW'(g));
        if (HDR != 0) exp_q.push_back(HDR_TAG | 8'(g));
        l = 1'b0;
        while (!l && m_b[g].size() > 0) begin
          exp_q.push_back(m_b[g].pop_front());
          l = m_l[g].pop_front();
        end
        m_last = g;
      end
    end while (found);
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic l, input int gap, input bit to_model);
    drv_b[r].push_back(b);
    drv_l[r].push_back(l);
    drv_g[r].push_back(gap);
    if (to_model) begin
      m_b[r].push_back(b);
      m_l[r].push_back(l);
    end
  endtask

  task automatic push_msg(input int r, input int len, input int max_gap);
    for (int j = 0; j < len; j++)
      push_byte(r, 8'($urandom_range(0, 255)), (j == len - 1),
                (j == 0) ? 0 : int'($urandom_range(0, max_gap)), 1'b1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (n < budget && !(exp_q.size() == 0 && exp_g.size() == 0 && !busy && drv_empty()));
    check({name, "_drained"}, (n < budget), 1'b1);
  endtask

  task automatic wait_writes(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && wr_count < target) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_writes_seen"}, (wr_count >= target), 1'b1);
  endtask

  // driver: handshake sampled at negedge, queues advanced and inputs driven #1 after posedge
  initial begin
    req_valid = '0; req_last = '0; req_data = '0; txfifo_full = 1'b0;
    for (int r = 0; r < NREQ; r++) rise_cyc[r] = 0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!rst && hs[i] && drv_b[i].size() > 0) begin
          void'(drv_b[i].pop_front());
          void'(drv_l[i].pop_front());
          void'(drv_g[i].pop_front());
        end
        if (drv_b[i].size() > 0 && drv_g[i][0] > 0) begin
          drv_g[i][0] = drv_g[i][0] - 1;
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end else if (drv_b[i].size() > 0) begin
          if (!req_valid[i]) rise_cyc[i] = cyc;
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = drv_b[i][0];
          req_last[i] = drv_l[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      if (full_hold > 0) begin
        txfifo_full = 1'b1;
        full_hold--;
      end else begin
        txfifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        grant_cyc = cyc;
        if (exp_g.size() == 0) fail_now("grant_unexpected", $sformatf("got grant %0d, none expected", grant_id));
        else check("grant_id", grant_id, exp_g.pop_front());
      end
      if (txdata_valid && !txfifo_full) begin
        if (exp_q.size() == 0) fail_now("txdata_unexpected", $sformatf("got %0h, none expected", txdata));
        else check("txdata", txdata, exp_q.pop_front());
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
      end
      if (txfifo_full && busy) check("ready_while_full", req_ready, '0);
      if (abort) begin
        abort_seen++;
        abort_gap = cyc - last_wr_cyc;
        check("busy_at_abort", busy, 1'b0);
      end
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_abort", abort, 1'b0);
    check("rst_txdata_valid", txdata_valid, 1'b0);
    check("rst_req_ready", req_ready, '0);
    check("rst_txdata", txdata, 8'h00);
    check("rst_grant_id", grant_id, '0);
    #1 rst = 1'b0;

    // round robin: requesters 0, 1, 3 with 2-byte messages, no backpressure
    push_msg(0, 2, 0); push_msg(1, 2, 0); push_msg(3, 2, 0);
    model_run();
    first_wr_cyc = -1;
    wait_idle("rr", 200);
    check("rr_span", last_wr_cyc - first_wr_cyc, 2 * (1 + HDR + 2) + HDR + 2 - 1);

    // watchdog: requester 0 stops after its first byte, requester 1 waiting
    push_byte(0, 8'h11, 1'b0, 0, 1'b0);
    exp_g.push_back(GW'(0));
    if (HDR != 0) exp_q.push_back(HDR_TAG | 8'h00);
    exp_q.push_back(8'h11);
    m_last = 0;
    exp_aborts++;
    push_msg(1, 3, 0);
    model_run();
    wait_idle("wdog", 300);
    check("wdog_abort_count", abort_seen, exp_aborts);
    check("wdog_abort_gap", abort_gap, TIMEOUT + 1);

    // last byte arrives on the cycle the watchdog would otherwise expire
    push_byte(2, 8'($urandom_range(0, 255)), 1'b0, 0, 1'b1);
    push_byte(2, 8'($urandom_range(0, 255)), 1'b0, TIMEOUT - 1, 1'b1);
    push_byte(2, 8'($urandom_range(0, 255)), 1'b1, TIMEOUT - 1, 1'b1);
    model_run();
    wait_idle("coinc", 300);
    check("coinc_no_abort", abort_seen, exp_aborts);

    // backpressure: 5 full cycles in the middle of requester 2's 4-byte message
    push_msg(2, 4, 0);
    model_run();
    wait_writes("bp", wr_count + 1 + HDR, 50);
    full_hold = 5;
    wait_idle("bp", 300);
    check("bp_no_abort", abort_seen, exp_aborts);

    // lone requester is re-granted for each message
    push_msg(2, $urandom_range(1, 3), 0);
    push_msg(2, $urandom_range(1, 3), 0);
    push_msg(2, $urandom_range(1, 3), 0);
    model_run();
    wait_idle("regrant", 300);

    // single-byte message latency
    push_byte(3, 8'h55, 1'b1, 0, 1'b1);
    model_run();
    wait_idle("single", 100);
    check("single_grant_latency", grant_cyc - rise_cyc[3], 1);
    check("single_write_latency", last_wr_cyc - rise_cyc[3], 1 + HDR);

    // randomized traffic with random backpressure and short mid-message gaps
    rand_full = 1'b1;
    for (int round = 0; round < 40; round++) begin
      int mask;
      mask = $urandom_range(1, (1 << NREQ) - 1);
      for (int r = 0; r < NREQ; r++)
        if (mask[r]) begin
          int nmsg;
          nmsg = $urandom_range(1, 2);
          for (int m = 0; m < nmsg; m++) push_msg(r, $urandom_range(1, 4), TIMEOUT - 3);
        end
      model_run();
      wait_idle("rand", 2000);
    end
    rand_full = 1'b0;
    check("rand_no_abort", abort_seen, exp_aborts);

    // reset mid-message: requester 0 completes first, then requester 1 is cut off
    push_msg(0, 1, 0);
    model_run();
    wait_idle("pre_rst", 100);
    for (int j = 0; j < 6; j++) push_byte(1, 8'($urandom_range(0, 255)), (j == 5), 0, 1'b1);
    model_run();
    wait_writes("mid", wr_count + 2 + HDR, 50);
    @(negedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    exp_g.delete();
    for (int r = 0; r < NREQ; r++) begin
      drv_b[r].delete(); drv_l[r].delete(); drv_g[r].delete();
      m_b[r].delete(); m_l[r].delete();
    end
    m_last = NREQ - 1;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_abort", abort, 1'b0);
    check("mrst_txdata_valid", txdata_valid, 1'b0);
    check("mrst_req_ready", req_ready, '0);
    check("mrst_txdata", txdata, 8'h00);
    check("mrst_grant_id", grant_id, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("mrst_busy_after", busy, 1'b0);
    push_msg(1, 2, 0);
    push_msg(0, 2, 0);
    model_run();
    wait_idle("post_rst", 200);
    check("final_abort_count", abort_seen, exp_aborts);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
